// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_controller
// Brief    : Holds the CPU in reset after start, then runs it until a halt or timeout.
// Revision : 1.0
// ============================================================================
module cpu_run_controller #(
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 800,
    parameter int STALL_LIMIT  = 8,
    parameter int PC_WIDTH     = 64,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 retire,
    output logic                 cpu_reset,
    output logic                 running,
    output logic                 done,
    output logic                 halted,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retired_count
);

    localparam int c_HOLD_W  = (RESET_CYCLES <= 1) ? 1 : $clog2(RESET_CYCLES);
    localparam int c_STALL_W = (STALL_LIMIT <= 0) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam bit c_HALT_EN = (STALL_LIMIT != 0);

    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST   = c_HOLD_W'(RESET_CYCLES - 1);
    localparam logic [c_STALL_W-1:0] c_STALL_LIMIT = c_STALL_W'(STALL_LIMIT);
    localparam logic [CNT_WIDTH-1:0] c_MAX_CYCLES  = CNT_WIDTH'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_RESET_HOLD = 2'd1,
        S_RUN        = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [c_HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [c_STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [PC_WIDTH-1:0]    pc_prev_q, pc_prev_d;
    logic                   pc_seen_q, pc_seen_d;
    logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
    logic [CNT_WIDTH-1:0]   retired_count_q, retired_count_d;
    logic                   halted_q, halted_d;
    logic                   timeout_q, timeout_d;

    logic                   w_pc_same;
    logic [c_STALL_W-1:0]   w_stall_inc;
    logic [CNT_WIDTH-1:0]   w_cycle_inc;
    logic                   w_halt;
    logic                   w_timeout;

    // The first RUN cycle has no previous PC, so it can never count as a stall.
    assign w_pc_same   = pc_seen_q && (pc == pc_prev_q);
    assign w_stall_inc = stall_cnt_q + c_STALL_W'(1);
    assign w_cycle_inc = cycle_count_q + CNT_WIDTH'(1);
    assign w_halt      = c_HALT_EN && w_pc_same && (w_stall_inc == c_STALL_LIMIT);
    assign w_timeout   = (w_cycle_inc == c_MAX_CYCLES);

    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        pc_prev_d       = pc_prev_q;
        pc_seen_d       = pc_seen_q;
        cycle_count_d   = cycle_count_q;
        retired_count_d = retired_count_q;
        halted_d        = halted_q;
        timeout_d       = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d         = S_RESET_HOLD;
                    hold_cnt_d      = '0;
                    stall_cnt_d     = '0;
                    pc_seen_d       = 1'b0;
                    cycle_count_d   = '0;
                    retired_count_d = '0;
                    halted_d        = 1'b0;
                    timeout_d       = 1'b0;
                end
            end
            S_RESET_HOLD: begin
                hold_cnt_d = hold_cnt_q + c_HOLD_W'(1);
                if (hold_cnt_q == c_HOLD_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cycle_count_d = w_cycle_inc;
                if (retire) begin
                    retired_count_d = retired_count_q + CNT_WIDTH'(1);
                end
                pc_prev_d   = pc;
                pc_seen_d   = 1'b1;
                stall_cnt_d = w_pc_same ? w_stall_inc : '0;
                if (w_halt) begin
                    halted_d = 1'b1;
                end
                if (w_timeout) begin
                    timeout_d = 1'b1;
                end
                if (w_halt || w_timeout) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            hold_cnt_q      <= '0;
            stall_cnt_q     <= '0;
            pc_prev_q       <= '0;
            pc_seen_q       <= 1'b0;
            cycle_count_q   <= '0;
            retired_count_q <= '0;
            halted_q        <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            pc_prev_q       <= pc_prev_d;
            pc_seen_q       <= pc_seen_d;
            cycle_count_q   <= cycle_count_d;
            retired_count_q <= retired_count_d;
            halted_q        <= halted_d;
            timeout_q       <= timeout_d;
        end
    end

    assign cpu_reset     = (state_q == S_IDLE) || (state_q == S_RESET_HOLD);
    assign running       = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign halted        = halted_q;
    assign timeout       = timeout_q;
    assign cycle_count   = cycle_count_q;
    assign retired_count = retired_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_controller
// Brief    : Directed self-checking bench for cpu_run_controller.
// Revision : 1.0
// ============================================================================
module tb_cpu_run_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start_b;
    logic [63:0] pc;
    logic        retire;

    logic        cpu_reset, running, done, halted, timeout;
    logic [31:0] cycle_count, retired_count;
    logic        cpu_reset_b, running_b, done_b, halted_b, timeout_b;
    logic [31:0] cycle_count_b, retired_count_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cpu_run_controller #(
        .RESET_CYCLES(3), .MAX_CYCLES(20), .STALL_LIMIT(4), .PC_WIDTH(64), .CNT_WIDTH(32)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .retire(retire),
        .cpu_reset(cpu_reset), .running(running), .done(done), .halted(halted),
        .timeout(timeout), .cycle_count(cycle_count), .retired_count(retired_count)
    );

    // Second instance with halt detection disabled.
    cpu_run_controller #(
        .RESET_CYCLES(3), .MAX_CYCLES(20), .STALL_LIMIT(0), .PC_WIDTH(64), .CNT_WIDTH(32)
    ) u_dut_nohalt (
        .clk(clk), .reset(reset), .start(start_b), .pc(pc), .retire(retire),
        .cpu_reset(cpu_reset_b), .running(running_b), .done(done_b), .halted(halted_b),
        .timeout(timeout_b), .cycle_count(cycle_count_b), .retired_count(retired_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit use_b);
        if (use_b) start_b = 1'b1; else start = 1'b1;
        tick();
        start   = 1'b0;
        start_b = 1'b0;
    endtask

    // Drives one RUN-cycle pattern until the selected instance reports done (bounded).
    task automatic run_to_done(input int mode, input bit use_b, output int end_k);
        end_k = -1;
        for (int k = 1; k <= 40; k++) begin
            case (mode)
                0: begin pc = 64'(4 * k); retire = k[0]; end
                1: begin pc = 64'(64 - 4 * (6 - ((k < 6) ? k : 6))); retire = 1'b1; end
                2: begin pc = 64'(64 - 4 * (16 - ((k < 16) ? k : 16))); retire = 1'b0; end
                default: begin pc = 64'h100; retire = ((k % 3) == 0); end
            endcase
            tick();
            if (use_b ? done_b : done) begin
                end_k = k;
                break;
            end
        end
        retire = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_b = 1'b0; pc = '0; retire = 1'b0;
        repeat (2) tick();
        total_cnt++; if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0) $display("FAIL reset_outputs: got cpu_reset=%b running=%b done=%b want 1 0 0", cpu_reset, running, done); else pass_cnt++;
        reset = 1'b0;
        repeat (5) tick();
        total_cnt++; if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0) $display("FAIL idle_hold: got cpu_reset=%b running=%b done=%b want 1 0 0", cpu_reset, running, done); else pass_cnt++;
        total_cnt++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) $display("FAIL idle_counts: got cycles=%0d retired=%0d want 0 0", cycle_count, retired_count); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0 || timeout !== 1'b0) $display("FAIL idle_flags: got halted=%b timeout=%b want 0 0", halted, timeout); else pass_cnt++;
        total_cnt++; if (cpu_reset_b !== 1'b1 || done_b !== 1'b0) $display("FAIL idle_b: got cpu_reset=%b done=%b want 1 0", cpu_reset_b, done_b); else pass_cnt++;
    endtask

    task automatic test_reset_hold();
        pulse_start(1'b0);
        for (int i = 1; i <= 3; i++) begin
            total_cnt++; if (cpu_reset !== 1'b1 || running !== 1'b0) $display("FAIL hold_cycle%0d: got cpu_reset=%b running=%b want 1 0", i, cpu_reset, running); else pass_cnt++;
            if (i < 3) tick();
        end
        tick();
        total_cnt++; if (running !== 1'b1 || cpu_reset !== 1'b0) $display("FAIL hold_to_run: got running=%b cpu_reset=%b want 1 0", running, cpu_reset); else pass_cnt++;
        total_cnt++; if (cycle_count !== 32'd0) $display("FAIL run_start_count: got %0d want 0", cycle_count); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int end_k;
        run_to_done(0, 1'b0, end_k);
        total_cnt++; if (end_k !== 20) $display("FAIL timeout_end_cycle: got %0d want 20", end_k); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b1 || halted !== 1'b0) $display("FAIL timeout_flags: got timeout=%b halted=%b want 1 0", timeout, halted); else pass_cnt++;
        total_cnt++; if (cycle_count !== 32'd20 || retired_count !== 32'd10) $display("FAIL timeout_counts: got cycles=%0d retired=%0d want 20 10", cycle_count, retired_count); else pass_cnt++;
        total_cnt++; if (cpu_reset !== 1'b0 || running !== 1'b0) $display("FAIL done_outputs: got cpu_reset=%b running=%b want 0 0", cpu_reset, running); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            pc = 64'(i); retire = 1'b1;
            tick();
            total_cnt++; if (done !== 1'b1 || cycle_count !== 32'd20 || retired_count !== 32'd10 || timeout !== 1'b1) $display("FAIL frozen_%0d: got done=%b cycles=%0d retired=%0d timeout=%b want 1 20 10 1", i, done, cycle_count, retired_count, timeout); else pass_cnt++;
        end
        retire = 1'b0;
    endtask

    task automatic test_restart();
        pulse_start(1'b0);
        total_cnt++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) $display("FAIL restart_counts: got cycles=%0d retired=%0d want 0 0", cycle_count, retired_count); else pass_cnt++;
        total_cnt++; if (timeout !== 1'b0 || halted !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b1) $display("FAIL restart_state: got timeout=%b halted=%b done=%b cpu_reset=%b want 0 0 0 1", timeout, halted, done, cpu_reset); else pass_cnt++;
        repeat (2) tick();
        total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL restart_hold: got cpu_reset=%b want 1", cpu_reset); else pass_cnt++;
        tick();
        total_cnt++; if (running !== 1'b1) $display("FAIL restart_run: got running=%b want 1", running); else pass_cnt++;
    endtask

    task automatic test_halt();
        int end_k;
        run_to_done(1, 1'b0, end_k);
        total_cnt++; if (end_k !== 10) $display("FAIL halt_end_cycle: got %0d want 10", end_k); else pass_cnt++;
        total_cnt++; if (halted !== 1'b1 || timeout !== 1'b0) $display("FAIL halt_flags: got halted=%b timeout=%b want 1 0", halted, timeout); else pass_cnt++;
        total_cnt++; if (cycle_count !== 32'd10 || retired_count !== 32'd10) $display("FAIL halt_counts: got cycles=%0d retired=%0d want 10 10", cycle_count, retired_count); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int end_k;
        pulse_start(1'b0);
        repeat (3) tick();
        run_to_done(2, 1'b0, end_k);
        total_cnt++; if (end_k !== 20) $display("FAIL both_end_cycle: got %0d want 20", end_k); else pass_cnt++;
        total_cnt++; if (halted !== 1'b1 || timeout !== 1'b1) $display("FAIL both_flags: got halted=%b timeout=%b want 1 1", halted, timeout); else pass_cnt++;
        total_cnt++; if (cycle_count !== 32'd20 || retired_count !== 32'd0) $display("FAIL both_counts: got cycles=%0d retired=%0d want 20 0", cycle_count, retired_count); else pass_cnt++;
    endtask

    task automatic test_start_in_run_and_abort();
        pulse_start(1'b0);
        repeat (3) tick();
        for (int k = 1; k <= 6; k++) begin
            pc = 64'(4 * k); retire = 1'b1;
            start = (k == 4);
            tick();
            start = 1'b0;
            if (k == 4) begin
                total_cnt++; if (running !== 1'b1 || cpu_reset !== 1'b0 || cycle_count !== 32'd4) $display("FAIL start_in_run: got running=%b cpu_reset=%b cycles=%0d want 1 0 4", running, cpu_reset, cycle_count); else pass_cnt++;
            end
        end
        total_cnt++; if (cycle_count !== 32'd6 || retired_count !== 32'd6) $display("FAIL pre_abort_counts: got cycles=%0d retired=%0d want 6 6", cycle_count, retired_count); else pass_cnt++;
        retire = 1'b0;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (cpu_reset !== 1'b1 || running !== 1'b0) $display("FAIL async_abort: got cpu_reset=%b running=%b want 1 0", cpu_reset, running); else pass_cnt++;
        total_cnt++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) $display("FAIL abort_counts: got cycles=%0d retired=%0d want 0 0", cycle_count, retired_count); else pass_cnt++;
        tick();
        reset = 1'b0;
        tick();
        total_cnt++; if (cpu_reset !== 1'b1 || done !== 1'b0 || running !== 1'b0) $display("FAIL post_abort_idle: got cpu_reset=%b done=%b running=%b want 1 0 0", cpu_reset, done, running); else pass_cnt++;
    endtask

    task automatic test_no_halt();
        int end_k;
        pulse_start(1'b1);
        repeat (3) tick();
        total_cnt++; if (running_b !== 1'b1) $display("FAIL nohalt_run: got running=%b want 1", running_b); else pass_cnt++;
        run_to_done(3, 1'b1, end_k);
        total_cnt++; if (end_k !== 20) $display("FAIL nohalt_end_cycle: got %0d want 20", end_k); else pass_cnt++;
        total_cnt++; if (timeout_b !== 1'b1 || halted_b !== 1'b0) $display("FAIL nohalt_flags: got timeout=%b halted=%b want 1 0", timeout_b, halted_b); else pass_cnt++;
        total_cnt++; if (cycle_count_b !== 32'd20 || retired_count_b !== 32'd6) $display("FAIL nohalt_counts: got cycles=%0d retired=%0d want 20 6", cycle_count_b, retired_count_b); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reset_hold();
        test_timeout();
        test_restart();
        test_halt();
        test_simultaneous();
        test_start_in_run_and_abort();
        test_no_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Synthesizable run controller that replaces a fixed "reset one cycle, run N cycles, stop" bench sequence for the 5-stage pipelined CPU.
- Holds the CPU in reset for a parametrised number of cycles after a start pulse, then lets it run.
- Counts run cycles and retired instructions.
- Ends the run on a cycle-budget timeout or on halt detection, where halt means the PC stays unchanged for a parametrised number of consecutive cycles.
- Sits beside the `cpu` instance; drives its reset and observes its PC and writeback-retire strobe.

Parameters:
- RESET_CYCLES, 1, cycles cpu_reset is held high after start; must be >= 1.
- MAX_CYCLES, 800, run-cycle budget before timeout; must be >= 1.
- STALL_LIMIT, 8, consecutive unchanged-PC comparisons that signal halt; 0 disables halt detection.
- PC_WIDTH, 64, width of the observed PC.
- CNT_WIDTH, 32, width of the cycle and retire counters; must hold MAX_CYCLES.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-high; returns the block to IDLE immediately.
- start, input, 1, single-cycle request to begin a run.
- pc, input, PC_WIDTH, CPU fetch PC, sampled each RUN cycle.
- retire, input, 1, one instruction committed in WB this cycle.
- cpu_reset, output, 1, reset to the CPU.
- running, output, 1, high while in RUN.
- done, output, 1, high while in DONE.
- halted, output, 1, run ended by halt detection.
- timeout, output, 1, run ended by cycle budget.
- cycle_count, output, CNT_WIDTH, RUN cycles elapsed in the current or last run.
- retired_count, output, CNT_WIDTH, retire strobes seen in RUN during the current or last run.

Behaviour:
- States: IDLE, RESET_HOLD, RUN, DONE. State and all counters are registered.
- Outputs are decoded from registered state only:
  - cpu_reset = (state == IDLE || state == RESET_HOLD).
  - running = (state == RUN).
  - done = (state == DONE).
- Async reset: state=IDLE, hold_cnt=0, stall_cnt=0, pc_prev=0, pc_seen=0, cycle_count=0, retired_count=0, halted=0, timeout=0. Resulting outputs: cpu_reset=1, running=0, done=0.
- IDLE:
  - start=1 -> RESET_HOLD.
  - On that same edge: clear both counters, both flags, hold_cnt, stall_cnt and pc_seen.
- RESET_HOLD:
  - hold_cnt increments each cycle.
  - When hold_cnt == RESET_CYCLES-1 -> RUN. cpu_reset is therefore high for exactly RESET_CYCLES cycles in RESET_HOLD.
  - start is ignored.
- RUN, on each edge:
  - cycle_count += 1.
  - If retire=1, retired_count += 1.
  - pc_prev <= pc and pc_seen <= 1.
  - If pc_seen && pc == pc_prev, stall_cnt += 1; otherwise stall_cnt <= 0.
- Halt condition:
  - STALL_LIMIT != 0, pc_seen, pc == pc_prev, and stall_cnt+1 == STALL_LIMIT.
  - Action: set halted=1 and go to DONE.
- Timeout condition:
  - cycle_count+1 == MAX_CYCLES.
  - Action: set timeout=1 and go to DONE.
- Both conditions on the same edge: both flags set, go to DONE.
- The counter increments and the retire count of the terminating cycle are included in the final values.
- The first RUN cycle never counts as a stall (pc_seen=0).
- start is ignored in RUN; runs are not preemptible except by reset.
- DONE:
  - cpu_reset=0; CPU state is left intact for inspection.
  - Counters and flags are frozen.
  - start=1 -> RESET_HOLD with the same clears as from IDLE.
- Counters never wrap: the MAX_CYCLES timeout ends the run before overflow, and retired_count <= cycle_count.
- stall_cnt width is clog2(STALL_LIMIT+1), minimum 1 bit.
- Reset asserted mid-run or mid-hold aborts immediately to the reset values above; cpu_reset goes high asynchronously.

Test Plan:
- Reset/idle. Set RESET_CYCLES=3, MAX_CYCLES=20, STALL_LIMIT=4. Assert reset, then release with no start -> cpu_reset=1, running=0, done=0, both counts 0, held indefinitely.
- Reset-hold length. Pulse start -> cpu_reset high for exactly 3 cycles after the start edge, then running=1 on the next cycle.
- Timeout. PC increments every cycle and retire=1 on every other RUN cycle -> done=1, timeout=1, halted=0, cycle_count=20, retired_count=10; values stay frozen for 10 further cycles.
- Halt. PC increments for 5 RUN cycles, then sticks at 0x40 -> halted=1 after 4 consecutive equal comparisons; cycle_count=10, timeout=0.
- Simultaneous end. Tune the PC stick point so the 4th equal comparison lands on RUN cycle 20 -> halted=1, timeout=1, cycle_count=20.
- Restart/abort.
  - Pulse start in DONE -> counters and flags clear and reset-hold repeats.
  - Pulse start in RUN -> ignored.
  - Assert reset at RUN cycle 7 -> immediate return to IDLE values with cpu_reset=1 asynchronously.
  - Rerun with STALL_LIMIT=0 and a constant PC -> only timeout fires.
